// File: rtl/riscv_core_mem_arbiter_if.sv
// riscv_core_mem_arbiter_if: requester and memory-port signals of the core memory arbiter
interface riscv_core_mem_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]          ch_req;
    logic [NUM_CH-1:0]          ch_we;
    logic [NUM_CH*ADDR_W-1:0]   ch_addr;
    logic [NUM_CH*DATA_W-1:0]   ch_wdata;
    logic [NUM_CH*DATA_W/8-1:0] ch_wstrb;
    logic [NUM_CH-1:0]          ch_done;
    logic [NUM_CH-1:0]          ch_err;
    logic [DATA_W-1:0]          ch_rdata;
    logic                       mem_valid;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [DATA_W/8-1:0]        mem_wstrb;
    logic                       mem_done;
    logic [DATA_W-1:0]          mem_rdata;

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, ch_wstrb, mem_done, mem_rdata,
        input  ch_done, ch_err, ch_rdata, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, ch_wstrb, mem_done, mem_rdata,
        output ch_done, ch_err, ch_rdata, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/riscv_core_mem_arbiter.sv
// riscv_core_mem_arbiter: merges NUM_CH cache requesters onto one memory port,
// fixed or round-robin priority, one outstanding transaction, optional timeout.
module riscv_core_mem_arbiter #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int NUM_CH  = 2,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 1024
) (
    input logic i_riscv_core_clk,
    input logic i_riscv_core_rst,
    riscv_core_mem_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_CH);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       grant, last_grant, winner;
    logic [CW-1:0]       cnt;
    logic                found, timeout_hit;
    int                  idx;
    logic                mem_valid, mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata, ch_rdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [NUM_CH-1:0]   ch_done, ch_err;

    assign bus.mem_valid = mem_valid;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_wstrb = mem_wstrb;
    assign bus.ch_done   = ch_done;
    assign bus.ch_err    = ch_err;
    assign bus.ch_rdata  = ch_rdata;

    // Round-robin search starts just after the previous winner; fixed mode starts at 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = RR_MODE != 0 ? (int'(last_grant) + 1 + i) % NUM_CH : i;
            if (!found && bus.ch_req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    always_comb begin
        timeout_hit = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
        state_nxt   = state;
        state_nxt   = state == IDLE ? (found ? BUSY : IDLE) :
                      state == BUSY ? ((bus.mem_done || timeout_hit) ? RESP : BUSY) : IDLE;
    end

    always_ff @(posedge i_riscv_core_clk) begin
        if (i_riscv_core_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(NUM_CH - 1);
            cnt        <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            ch_done    <= '0;
            ch_err     <= '0;
            ch_rdata   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= '0;
            ch_done  <= '0;
            ch_err   <= '0;
            ch_rdata <= '0;
            if (state == IDLE && found) begin
                grant      <= winner;
                last_grant <= winner;
                mem_valid  <= 1'b1;
                mem_we     <= bus.ch_we[winner];
                mem_addr   <= bus.ch_addr[int'(winner)*ADDR_W +: ADDR_W];
                mem_wdata  <= bus.ch_wdata[int'(winner)*DATA_W +: DATA_W];
                mem_wstrb  <= bus.ch_wstrb[int'(winner)*(DATA_W/8) +: DATA_W/8];
            end
            if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                // A done arriving on the timeout cycle still counts as a normal completion.
                if (state_nxt == RESP) begin
                    mem_valid <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    mem_wstrb <= '0;
                    ch_done   <= NUM_CH'(1) << grant;
                    ch_err    <= bus.mem_done ? '0 : NUM_CH'(1) << grant;
                    ch_rdata  <= bus.mem_done && !mem_we ? bus.mem_rdata : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// tb_riscv_core_mem_arbiter: directed tests of the memory arbiter in round-robin and fixed modes
module tb_riscv_core_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    logic [1:0] seen [4];

    always #5 clk = ~clk;

    riscv_core_mem_arbiter_if #(.DATA_W(64), .ADDR_W(64), .NUM_CH(2)) bus_rr ();
    riscv_core_mem_arbiter_if #(.DATA_W(64), .ADDR_W(64), .NUM_CH(2)) bus_fx ();

    riscv_core_mem_arbiter #(.DATA_W(64), .ADDR_W(64), .NUM_CH(2), .RR_MODE(1), .TIMEOUT(8)) dut_rr (
        .i_riscv_core_clk(clk),
        .i_riscv_core_rst(rst),
        .bus(bus_rr)
    );

    riscv_core_mem_arbiter #(.DATA_W(64), .ADDR_W(64), .NUM_CH(2), .RR_MODE(0), .TIMEOUT(8)) dut_fx (
        .i_riscv_core_clk(clk),
        .i_riscv_core_rst(rst),
        .bus(bus_fx)
    );

    task automatic clear_inputs();
        bus_rr.ch_req = '0; bus_rr.ch_we = '0; bus_rr.ch_addr = '0; bus_rr.ch_wdata = '0;
        bus_rr.ch_wstrb = '0; bus_rr.mem_done = 1'b0; bus_rr.mem_rdata = '0;
        bus_fx.ch_req = '0; bus_fx.ch_we = '0; bus_fx.ch_addr = '0; bus_fx.ch_wdata = '0;
        bus_fx.ch_wstrb = '0; bus_fx.mem_done = 1'b0; bus_fx.mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus_rr.mem_valid, bus_rr.mem_we, bus_rr.mem_addr, bus_rr.mem_wdata, bus_rr.mem_wstrb} !== '0) begin
            fails++; $display("FAIL reset_rr_mem: got valid=%b addr=%h expected all zero", bus_rr.mem_valid, bus_rr.mem_addr);
        end
        checks++;
        if ({bus_rr.ch_done, bus_rr.ch_err, bus_rr.ch_rdata} !== '0) begin
            fails++; $display("FAIL reset_rr_ch: got done=%b err=%b rdata=%h expected zero", bus_rr.ch_done, bus_rr.ch_err, bus_rr.ch_rdata);
        end
        checks++;
        if ({bus_fx.mem_valid, bus_fx.mem_we, bus_fx.mem_addr, bus_fx.mem_wdata, bus_fx.mem_wstrb} !== '0) begin
            fails++; $display("FAIL reset_fx_mem: got valid=%b addr=%h expected all zero", bus_fx.mem_valid, bus_fx.mem_addr);
        end
        checks++;
        if ({bus_fx.ch_done, bus_fx.ch_err, bus_fx.ch_rdata} !== '0) begin
            fails++; $display("FAIL reset_fx_ch: got done=%b err=%b rdata=%h expected zero", bus_fx.ch_done, bus_fx.ch_err, bus_fx.ch_rdata);
        end
    endtask

    task automatic test_read();
        do_reset();
        bus_rr.ch_req = 2'b01;
        bus_rr.ch_addr[63:0] = 64'h8000_0000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus_rr.mem_valid !== 1'b1 || bus_rr.mem_we !== 1'b0 || bus_rr.mem_addr !== 64'h8000_0000 || bus_rr.ch_done !== 2'b00) begin
                fails++; $display("FAIL read_busy c%0d: got valid=%b we=%b addr=%h done=%b expected 1 0 80000000 00", c, bus_rr.mem_valid, bus_rr.mem_we, bus_rr.mem_addr, bus_rr.ch_done);
            end
        end
        bus_rr.mem_done = 1'b1;
        bus_rr.mem_rdata = 64'hDEAD_BEEF_0000_1111;
        @(negedge clk);
        checks++;
        if (bus_rr.ch_done !== 2'b01 || bus_rr.ch_err !== 2'b00 || bus_rr.ch_rdata !== 64'hDEAD_BEEF_0000_1111) begin
            fails++; $display("FAIL read_done: got done=%b err=%b rdata=%h expected 01 00 deadbeef00001111", bus_rr.ch_done, bus_rr.ch_err, bus_rr.ch_rdata);
        end
        bus_rr.mem_done = 1'b0;
        bus_rr.ch_req = 2'b00;
        @(negedge clk);
        checks++;
        if (bus_rr.ch_done !== 2'b00 || bus_rr.mem_valid !== 1'b0) begin
            fails++; $display("FAIL read_after: got done=%b valid=%b expected 00 0", bus_rr.ch_done, bus_rr.mem_valid);
        end
    endtask

    task automatic test_write();
        do_reset();
        bus_rr.ch_req = 2'b10;
        bus_rr.ch_we = 2'b10;
        bus_rr.ch_addr[127:64] = 64'h0000_0000_0000_1000;
        bus_rr.ch_wdata[127:64] = 64'h1122_3344_5566_7788;
        bus_rr.ch_wstrb[15:8] = 8'h0F;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus_rr.mem_valid !== 1'b1 || bus_rr.mem_we !== 1'b1 || bus_rr.mem_addr !== 64'h1000 ||
                bus_rr.mem_wdata !== 64'h1122_3344_5566_7788 || bus_rr.mem_wstrb !== 8'h0F) begin
                fails++; $display("FAIL write_payload c%0d: got v=%b we=%b a=%h d=%h s=%h expected 1 1 1000 1122334455667788 0f", c, bus_rr.mem_valid, bus_rr.mem_we, bus_rr.mem_addr, bus_rr.mem_wdata, bus_rr.mem_wstrb);
            end
            bus_rr.ch_wdata[127:64] = 64'hFFFF_0000_FFFF_0000;
            bus_rr.ch_wstrb[15:8] = 8'hFF;
        end
        bus_rr.mem_done = 1'b1;
        bus_rr.mem_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
        @(negedge clk);
        checks++;
        if (bus_rr.ch_done !== 2'b10 || bus_rr.ch_err !== 2'b00 || bus_rr.ch_rdata !== 64'h0) begin
            fails++; $display("FAIL write_done: got done=%b err=%b rdata=%h expected 10 00 0", bus_rr.ch_done, bus_rr.ch_err, bus_rr.ch_rdata);
        end
        clear_inputs();
    endtask

    task automatic test_rr();
        int n = 0;
        do_reset();
        for (int k = 0; k < 4; k++) seen[k] = 2'b00;
        bus_rr.ch_req = 2'b11;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (bus_rr.ch_done !== 2'b00) begin
                seen[n] = bus_rr.ch_done;
                n++;
            end
            bus_rr.mem_done = bus_rr.mem_valid;
        end
        clear_inputs();
        checks++;
        if (n != 4) begin
            fails++; $display("FAIL rr_count: got %0d completions expected 4", n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (seen[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL rr_grant%0d: got %b expected %b", k, seen[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task automatic test_fixed();
        int n = 0;
        do_reset();
        for (int k = 0; k < 4; k++) seen[k] = 2'b00;
        bus_fx.ch_req = 2'b11;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (bus_fx.ch_done !== 2'b00) begin
                seen[n] = bus_fx.ch_done;
                n++;
            end
            bus_fx.mem_done = bus_fx.mem_valid;
        end
        clear_inputs();
        checks++;
        if (n != 4) begin
            fails++; $display("FAIL fixed_count: got %0d completions expected 4", n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (seen[k] !== 2'b01) begin
                fails++; $display("FAIL fixed_grant%0d: got %b expected 01", k, seen[k]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus_rr.ch_req = 2'b01;
        bus_rr.mem_rdata = 64'h1234_5678;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (bus_rr.mem_valid !== 1'b1 || bus_rr.ch_done !== 2'b00) begin
                fails++; $display("FAIL timeout_busy c%0d: got valid=%b done=%b expected 1 00", c, bus_rr.mem_valid, bus_rr.ch_done);
            end
        end
        @(negedge clk);
        checks++;
        if (bus_rr.ch_done !== 2'b01 || bus_rr.ch_err !== 2'b01 || bus_rr.ch_rdata !== 64'h0 || bus_rr.mem_valid !== 1'b0) begin
            fails++; $display("FAIL timeout_err: got done=%b err=%b rdata=%h valid=%b expected 01 01 0 0", bus_rr.ch_done, bus_rr.ch_err, bus_rr.ch_rdata, bus_rr.mem_valid);
        end
        bus_rr.ch_req = 2'b00;
        repeat (5) @(negedge clk);
        bus_rr.mem_done = 1'b1;
        @(negedge clk);
        bus_rr.mem_done = 1'b0;
        checks++;
        if (bus_rr.ch_done !== 2'b00 || bus_rr.ch_err !== 2'b00 || bus_rr.mem_valid !== 1'b0) begin
            fails++; $display("FAIL timeout_late: got done=%b err=%b valid=%b expected 00 00 0", bus_rr.ch_done, bus_rr.ch_err, bus_rr.mem_valid);
        end
    endtask

    task automatic test_done_on_timeout();
        do_reset();
        bus_rr.ch_req = 2'b01;
        repeat (8) @(negedge clk);
        bus_rr.mem_done = 1'b1;
        bus_rr.mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        checks++;
        if (bus_rr.ch_done !== 2'b01 || bus_rr.ch_err !== 2'b00 || bus_rr.ch_rdata !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            fails++; $display("FAIL edge_done: got done=%b err=%b rdata=%h expected 01 00 a5a5a5a5a5a5a5a5", bus_rr.ch_done, bus_rr.ch_err, bus_rr.ch_rdata);
        end
        bus_rr.ch_req = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus_rr.ch_done !== 2'b00 || bus_rr.mem_valid !== 1'b0) begin
                fails++; $display("FAIL idle_done c%0d: got done=%b valid=%b expected 00 0", c, bus_rr.ch_done, bus_rr.mem_valid);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_busy();
        do_reset();
        bus_rr.ch_req = 2'b01;
        bus_rr.ch_addr = {64'h200, 64'h100};
        bus_rr.ch_wdata = {64'h22, 64'h11};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_rr.mem_valid, bus_rr.mem_we, bus_rr.mem_addr, bus_rr.mem_wdata, bus_rr.mem_wstrb,
             bus_rr.ch_done, bus_rr.ch_err, bus_rr.ch_rdata} !== '0) begin
            fails++; $display("FAIL busy_reset: got valid=%b addr=%h done=%b expected all zero", bus_rr.mem_valid, bus_rr.mem_addr, bus_rr.ch_done);
        end
        rst = 1'b0;
        bus_rr.ch_req = 2'b11;
        @(negedge clk);
        checks++;
        if (bus_rr.mem_valid !== 1'b1 || bus_rr.mem_addr !== 64'h100) begin
            fails++; $display("FAIL post_reset_grant: got valid=%b addr=%h expected 1 100", bus_rr.mem_valid, bus_rr.mem_addr);
        end
        bus_rr.mem_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_rr.ch_done !== 2'b01) begin
            fails++; $display("FAIL post_reset_done: got %b expected 01", bus_rr.ch_done);
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_rr();
        test_fixed();
        test_timeout();
        test_done_on_timeout();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/riscv_core_mem_arbiter.md
# riscv_core_mem_arbiter

Parametrised memory-port arbiter that merges NUM_CH cache-side requesters (instruction-cache refill, data-cache refill/write-back, future page-table walker) onto the single external memory port of the core. It sits between the cache controllers and the AXI bridge inside the core top. It supports fixed or round-robin priority, read and write transactions, and a per-transaction timeout with error reporting. One transaction is outstanding at a time.

## Interface
- DATA_W, 64, data bus width (multiple of 8)
- ADDR_W, 64, address width
- NUM_CH, 2, requester channels (2..8)
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT, 1024, max cycles waiting for i_mem_done; 0 disables timeout
---
- i_riscv_core_clk  in  1  clock; all logic rising-edge
- i_riscv_core_rst  in  1  synchronous, active-high reset
- i_ch_req  in  NUM_CH  per-channel request valid
- i_ch_we  in  NUM_CH  per-channel write flag (1 = write)
- i_ch_addr  in  NUM_CH*ADDR_W  flattened addresses, channel c at [c*ADDR_W +: ADDR_W]
- i_ch_wdata  in  NUM_CH*DATA_W  flattened write data
- i_ch_wstrb  in  NUM_CH*DATA_W/8  flattened byte strobes
- o_ch_done  out  NUM_CH  one-cycle completion pulse, one-hot
- o_ch_err  out  NUM_CH  one-cycle error pulse (timeout), coincident with o_ch_done
- o_ch_rdata  out  DATA_W  read data, valid with o_ch_done
- o_mem_valid  out  1  downstream request valid
- o_mem_we  out  1  downstream write flag
- o_mem_addr  out  ADDR_W  downstream address
- o_mem_wdata  out  DATA_W  downstream write data
- o_mem_wstrb  out  DATA_W/8  downstream strobes
- i_mem_done  in  1  downstream completion (read data ready or write response)
- i_mem_rdata  in  DATA_W  downstream read data, valid with i_mem_done

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any i_ch_req is high, select winner, latch its we/addr/wdata/wstrb and index into registers, go BUSY. Otherwise stay.
- Fixed mode: the lowest requesting index wins.
- Round-robin mode: search starts at last_grant+1 modulo NUM_CH. last_grant updates at each grant.
- BUSY: o_mem_valid=1 and the downstream payload is driven from the latched registers, held stable. The timeout counter increments each BUSY cycle.
  - On i_mem_done: capture i_mem_rdata (zero for writes), go RESP.
  - If the counter reaches TIMEOUT-1 without done: abort, set err flag, rdata=0, go RESP.
  - Done on the timeout cycle takes priority: normal completion, no error.
- RESP: pulse o_ch_done[grant] (and o_ch_err[grant] if aborted), present o_ch_rdata, then go IDLE. The counter clears.
- i_mem_done outside BUSY is ignored. A late response after a timeout is discarded.
- Requester rule: keep i_ch_req high until its o_ch_done, and drop it the following cycle. Payload changes after grant have no effect.
- Reset: state IDLE; all outputs 0; last_grant=NUM_CH-1, so channel 0 wins first in RR mode; counter 0. Reset mid-transaction abandons it with no done pulse.

## Timing
- Request first seen high in cycle 0 (IDLE) → o_mem_valid high in cycle 1.
- i_mem_done in cycle k → o_ch_done/o_ch_rdata in cycle k+1 → IDLE in k+2 → the next grant's o_mem_valid in k+3.
- Minimum transaction 3 cycles (done in the first BUSY cycle). Throughput: one transaction per 3+memory-latency cycles.
- Timeout: o_mem_valid is high for exactly TIMEOUT cycles, then the err/done pulse follows in the next cycle.
- o_mem_* and o_ch_* are registered. There is no combinational path from i_mem_done to any output.

## Test plan
- Single read, ch0, addr 0x8000_0000, memory returns 0xDEAD_BEEF_0000_1111 two cycles after valid → o_mem_valid high cycles 1–3, o_ch_done[0] with that rdata in cycle 4, o_ch_err=0.
- Single write, ch1, wstrb 0x0F, data 0x1122334455667788 → o_mem_we=1 with payload held until done; o_ch_done[1] one cycle after i_mem_done, rdata 0.
- Both channels requesting continuously, RR_MODE=1 → grants alternate 0,1,0,1. With RR_MODE=0, ch0 wins every arbitration.
- TIMEOUT=8, memory never responds → o_mem_valid high exactly 8 cycles, then o_ch_done and o_ch_err pulse together, rdata 0. A late i_mem_done 5 cycles later produces no output.
- i_mem_done on the exact timeout cycle → normal completion, err=0. i_mem_done asserted in IDLE → ignored.
- i_riscv_core_rst asserted in BUSY → next cycle all outputs 0, state IDLE. The next request grants ch0 first.
